// File: rtl/adc_decim_fifo.sv
// Averages groups of 2^DECIM_LOG2 converter codes with round-half-up and
// buffers the results in a small FIFO drained through a valid/ready port.
module adc_decim_fifo #(
  parameter int unsigned DATA_W     = 4,
  parameter int unsigned DECIM_LOG2 = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [DATA_W-1:0]             code_in,
  input  logic                          code_valid,
  output logic [DATA_W-1:0]             m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [7:0]                    drop_cnt,
  input  logic                          clear_ovf
);

  localparam int unsigned N     = 1 << DECIM_LOG2;
  localparam int unsigned HALF  = N >> 1;
  localparam int unsigned ACC_W = DATA_W + DECIM_LOG2;
  localparam int unsigned SUM_W = ACC_W + 1;
  localparam int unsigned CNT_W = DECIM_LOG2;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0]   mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic                overflow_q, overflow_d;
  logic [7:0]          drop_cnt_q, drop_cnt_d;

  logic [SUM_W-1:0]    sum;
  logic [SUM_W-1:0]    avg;
  logic [DATA_W-1:0]   result;
  logic                push;
  logic                pop;
  logic                full;
  logic                wr;
  logic                drop;

  // Group accumulation and completion
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    sum     = SUM_W'(acc_q) + SUM_W'(code_in) + SUM_W'(HALF);
    avg     = sum >> DECIM_LOG2;
    result  = avg[DATA_W-1:0];

    case (state_q)
      IDLE: begin
        acc_d = '0;
        cnt_d = '0;
        if (enable) state_d = ACC;
      end
      ACC: begin
        if (!enable) begin
          // Dropping enable abandons the partial group without pushing
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end else if (code_valid) begin
          if (cnt_q == CNT_W'(N - 1)) begin
            push  = 1'b1;
            acc_d = '0;
            cnt_d = '0;
          end else begin
            acc_d = acc_q + ACC_W'(code_in);
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO bookkeeping and drop accounting
  always_comb begin
    pop  = m_valid & m_ready;
    full = (level_q == LVL_W'(FIFO_DEPTH));
    wr   = push & (~full | pop);
    drop = push & full & ~pop;

    mem_d = mem_q;
    if (wr) mem_d[wr_ptr_q] = result;

    wr_ptr_d = wr  ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d  = level_q + LVL_W'(wr) - LVL_W'(pop);

    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (clear_ovf) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
    // A drop in the same cycle as a clear restarts the count at one
    if (drop) begin
      overflow_d = 1'b1;
      if (clear_ovf)                drop_cnt_d = 8'd1;
      else if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Rounded average of DATA_W-bit codes always fits back into DATA_W bits
  assert property (@(posedge clk) disable iff (rst) push |-> ((avg >> DATA_W) == '0));

  assign m_data     = mem_q[rd_ptr_q];
  assign m_valid    = (level_q != '0);
  assign fifo_level = level_q;
  assign overflow   = overflow_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: doc/adc_decim_fifo.md
# adc_decim_fifo

Downstream consumer of the converter core's 4-bit output code. Accepts one code per qualified clock, averages each group of 2^DECIM_LOG2 codes with round-half-up, and buffers results in a small FIFO drained through a valid/ready port toward the digital readout. Drops on a full FIFO are counted and flagged; no data is ever stalled back into the converter.

## Interface
Parameters:
- DATA_W, 4, width of input code and averaged output
- DECIM_LOG2, 2, log2 of samples per average (N = 4); legal 1..6
- FIFO_DEPTH, 4, output FIFO entries; power of two, at least 2

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  system clock, same clock that drives the converter core
- rst  input  1  synchronous, active-high reset
- enable  input  1  averaging enable; low discards any partial group
- code_in  input  DATA_W  converter output code
- code_valid  input  1  code_in is a new sample this cycle
- m_data  output  DATA_W  averaged sample at FIFO head
- m_valid  output  1  FIFO non-empty
- m_ready  input  1  consumer accepts m_data this cycle
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current occupancy
- overflow  output  1  sticky: at least one result dropped
- drop_cnt  output  8  saturating count of dropped results
- clear_ovf  input  1  clears overflow and drop_cnt

## Operation
- FSM, two states:
  - IDLE: acc = 0, cnt = 0, samples ignored. Go to ACC when enable = 1; the first sample is accepted the cycle after the transition.
  - ACC: accept a sample on each edge with code_valid = 1. Go to IDLE when enable = 0; any partial sum is discarded and nothing is pushed.
- Accumulator is DATA_W+DECIM_LOG2 bits. cnt is DECIM_LOG2 bits and wraps from N-1 to 0.
- Group completion:
  - Condition: sample accepted with cnt = N-1.
  - result = (acc + code_in + N/2) >> DECIM_LOG2, computed at DATA_W+DECIM_LOG2+1 bits.
  - Result cannot exceed 2^DATA_W-1 (max sum + N/2 still truncates to max code), so no saturation is required. An assertion checks this.
  - Push result. acc and cnt restart at 0 on the same edge.
- FIFO push/pop:
  - pop = m_valid & m_ready.
  - When full, push with pop in the same cycle is accepted: level unchanged, no drop.
  - When full, push without pop is a drop. FIFO contents are unchanged, overflow is set to 1, and drop_cnt is incremented, saturating at 255.
  - When empty, there is no bypass: a pushed value first appears on m_valid/m_data the next cycle.
- clear_ovf:
  - Zeroes overflow and drop_cnt.
  - If a drop occurs in the same cycle, the drop wins: overflow = 1, drop_cnt = 1.
- enable does not affect the FIFO, which keeps draining while enable = 0.
- m_data is stable while m_valid = 1 and m_ready = 0.

## Timing
- Reset (rst = 1 at an edge):
  - state = IDLE, acc = 0, cnt = 0, FIFO emptied.
  - Outputs: m_valid = 0, m_data = 0, fifo_level = 0, overflow = 0, drop_cnt = 0.
  - Reset mid-group or with data in the FIFO discards everything. No output changes on the cycle after reset except as listed above.
- Latency: the edge accepting the Nth sample pushes the result, and m_valid = 1 after that edge (1 cycle).
- Throughput: one code per clock. One result per N accepted codes.
- Clearing m_valid:
  - m_valid drops after the edge that pops the last entry.
  - If a push coincides with that pop, m_valid stays 1 and the new data is presented.
- fifo_level reflects occupancy after each edge. It equals FIFO_DEPTH when full.
- Gaps in code_valid extend the group; cnt holds across gaps.

## Test plan
- Basic average:
  - Stimulus: enable = 1, m_ready = 1, codes 5, 5, 6, 6 on consecutive cycles.
  - Required response: m_valid pulses for one cycle after the 4th code edge, with m_data = 6 ((22+2)>>2).
- Rounding and extremes:
  - Codes 0, 0, 0, 1 give m_data = 0.
  - Codes 0, 0, 1, 1 give m_data = 1.
  - Codes 15, 15, 15, 15 give m_data = 15.
- Backpressure and drop:
  - m_ready = 0, 5 groups of constant code 3.
  - Required response: fifo_level reaches 4 and the 5th result sets overflow = 1, drop_cnt = 1.
  - Then m_ready = 1: four entries of 3 drain, and m_valid falls.
- Full with simultaneous push and pop:
  - FIFO full; m_ready = 1 on the cycle a 5th group completes.
  - Required response: no drop, fifo_level stays 4, output order preserved.
- Enable abort:
  - Two codes of 15, then enable = 0 for 1 cycle, then codes 2, 2, 2, 2.
  - Required response: a single result m_data = 2; the partial sum is discarded.
- Reset mid-operation:
  - Assert rst with 2 FIFO entries held and a group half-accumulated.
  - Required response: next cycle m_valid = 0 and fifo_level = 0. A fresh group 7, 7, 7, 7 then yields 7.
